adc_capture_window: RTL and testbench

ADC_CAPTURE_WINDOW -- requirements
Module: adc_capture_window

---
 rtl/rfsoc_config.sv | 30 +++
 rtl/capture_out_reg.sv | 66 ++++++
 rtl/adc_capture_window.sv | 182 ++++++++++++++++++
 tb/tb_adc_capture_window.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfsoc_config.sv
// ---------------------------------------------------------------------------
// rfsoc_config
//
// Shared definitions for the RFSoC ADC capture path.
//
// Contents:
//   CAP_CNT_W       default width of the capture delay / length counters
//   CAP_DATA_W      default width of one ADC AXIS beat (8 x 16-bit samples)
//   capture_state_t states of the capture window controller
//   state_is_busy   true whenever a capture is pending or in progress
// ---------------------------------------------------------------------------
package rfsoc_config;

  localparam int CAP_CNT_W  = 16;
  localparam int CAP_DATA_W = 128;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARMED   = 2'd1,
    CAP_DELAY   = 2'd2,
    CAP_CAPTURE = 2'd3
  } capture_state_t;

  // Anything other than IDLE means software has armed a window that has
  // not yet closed, so the controller reports itself as busy.
  function automatic logic state_is_busy(input capture_state_t s);
    return (s != CAP_IDLE);
  endfunction

endpackage

// File: rtl/capture_out_reg.sv
// ---------------------------------------------------------------------------
// capture_out_reg
//
// Single-entry AXI-Stream holding register carrying data plus a last flag.
// A beat offered on the input side is taken whenever the register is empty
// or its current contents are being accepted downstream in the same cycle,
// so a continuous stream passes through with one cycle of latency and no
// bubbles while out_ready stays high.
//
// Ports:
//   pl_clk     in   clock, rising edge
//   rst        in   synchronous active-high reset, clears all outputs
//   in_valid   in   a beat is offered this cycle
//   in_data    in   DATA_W beat payload
//   in_last    in   beat closes the packet
//   in_ready   out  the offered beat will be taken at the next edge
//   out_valid  out  register holds a beat
//   out_data   out  held payload, stable until accepted
//   out_last   out  held last flag, stable until accepted
//   out_ready  in   downstream accepts the held beat this cycle
// ---------------------------------------------------------------------------
module capture_out_reg #(
  parameter int DATA_W = 128
) (
  input  logic              pl_clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic              last_r;

  // Room exists if nothing is held, or the held beat leaves this cycle.
  assign in_ready = ~valid_r | out_ready;

  // Load a new beat when there is room; otherwise drain on acceptance.
  // While stalled (held beat, out_ready low) nothing changes, which keeps
  // data and last stable for the downstream consumer.
  always_ff @(posedge pl_clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      last_r  <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_r <= 1'b1;
      data_r  <= in_data;
      last_r  <= in_last;
    end else if (out_ready) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_last  = last_r;

endmodule

// File: rtl/adc_capture_window.sv
// ---------------------------------------------------------------------------
// adc_capture_window
//
// Cuts a fixed-length window out of the free-running RFSoC ADC stream. The
// host arms the block with a trigger delay and a window length; the next
// rising edge of the trigger line starts the delay countdown, after which
// capture_len valid beats are forwarded to adc_driver with tlast on the
// final one. The ADC is never back-pressured: if the output register is
// still full and downstream is stalled, the arriving beat is dropped and
// the sticky overflow flag marks the packet as invalid.
//
// Ports:
//   pl_clk         in   sole clock, rising edge
//   rst            in   synchronous active-high reset
//   arm            in   pulse: latch delay/length and wait for a trigger
//   abort          in   pulse: return to IDLE without a done pulse
//   trigger        in   level trigger (pl_clk domain), acts on rising edge
//   delay_cycles   in   CNT_W cycles from trigger edge to window start
//   capture_len    in   CNT_W window length in beats (0 = arm ignored)
//   s_axis_tdata   in   DATA_W ADC beat
//   s_axis_tvalid  in   ADC beat valid
//   s_axis_tready  out  always 1
//   m_axis_tdata   out  DATA_W captured beat
//   m_axis_tvalid  out  captured beat valid
//   m_axis_tready  in   downstream ready
//   m_axis_tlast   out  final beat of the window
//   busy           out  ARMED, DELAY or CAPTURE
//   done           out  one-cycle pulse when the window closes normally
//   overflow       out  sticky: a window beat was dropped since last arm
// ---------------------------------------------------------------------------
module adc_capture_window
  import rfsoc_config::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int CNT_W  = CAP_CNT_W
) (
  input  logic              pl_clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  input  logic [CNT_W-1:0]  delay_cycles,
  input  logic [CNT_W-1:0]  capture_len,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  capture_state_t   state;
  logic             trigger_q;
  logic [CNT_W-1:0] delay_lat;
  logic [CNT_W-1:0] len_lat;
  logic [CNT_W-1:0] delay_cnt;
  logic [CNT_W-1:0] beat_cnt;
  logic             overflow_r;
  logic             done_r;

  logic             trig_edge;
  logic             window_beat;
  logic [CNT_W-1:0] next_beat;
  logic             final_beat;
  logic             reg_in_ready;
  logic             beat_drop;

  // The ADC stream is free-running; beats outside the window simply fall
  // on the floor, so there is never a reason to stall it.
  assign s_axis_tready = 1'b1;

  assign trig_edge = trigger & ~trigger_q;

  // Every valid cycle inside the window counts toward the length, whether
  // or not the output register can take it. An abort in the same cycle
  // closes the window first, so that beat is not part of the packet.
  assign window_beat = (state == CAP_CAPTURE) & s_axis_tvalid & ~abort;
  assign next_beat   = beat_cnt + 1'b1;
  assign final_beat  = window_beat & (next_beat == len_lat);
  assign beat_drop   = window_beat & ~reg_in_ready;

  // Window controller. abort outranks arm, and a trigger edge only counts
  // once already sitting in ARMED, so an edge coinciding with arm (still in
  // IDLE) is not honoured, and edges during DELAY/CAPTURE cannot retrigger.
  always_ff @(posedge pl_clk) begin
    if (rst) begin
      state      <= CAP_IDLE;
      trigger_q  <= 1'b0;
      delay_lat  <= '0;
      len_lat    <= '0;
      delay_cnt  <= '0;
      beat_cnt   <= '0;
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      trigger_q <= trigger;
      done_r    <= 1'b0;

      if (beat_drop) begin
        overflow_r <= 1'b1;
      end

      if (abort) begin
        state <= CAP_IDLE;
      end else begin
        case (state)
          CAP_IDLE: begin
            if (arm && (capture_len != '0)) begin
              state      <= CAP_ARMED;
              delay_lat  <= delay_cycles;
              len_lat    <= capture_len;
              overflow_r <= 1'b0;
            end
          end

          // Loading delay-1 makes a delay of N put the first window beat
          // N+1 cycles after the edge, the same spacing as delay 0 -> 1.
          CAP_ARMED: begin
            if (trig_edge) begin
              beat_cnt <= '0;
              if (delay_lat == '0) begin
                state <= CAP_CAPTURE;
              end else begin
                state     <= CAP_DELAY;
                delay_cnt <= delay_lat - 1'b1;
              end
            end
          end

          // Counts pl_clk cycles, not ADC beats.
          CAP_DELAY: begin
            if (delay_cnt == '0) begin
              state <= CAP_CAPTURE;
            end else begin
              delay_cnt <= delay_cnt - 1'b1;
            end
          end

          CAP_CAPTURE: begin
            if (window_beat) begin
              beat_cnt <= next_beat;
              if (final_beat) begin
                state  <= CAP_IDLE;
                done_r <= 1'b1;
              end
            end
          end

          default: begin
            state <= CAP_IDLE;
          end
        endcase
      end
    end
  end

  // A dropped final beat never reaches the register, so no tlast is sent
  // for that packet and overflow is the only indication.
  capture_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .pl_clk    (pl_clk),
    .rst       (rst),
    .in_valid  (window_beat),
    .in_data   (s_axis_tdata),
    .in_last   (final_beat),
    .in_ready  (reg_in_ready),
    .out_valid (m_axis_tvalid),
    .out_data  (m_axis_tdata),
    .out_last  (m_axis_tlast),
    .out_ready (m_axis_tready)
  );

  assign busy     = state_is_busy(state);
  assign done     = done_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_adc_capture_window.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_window
//
// Directed bench for adc_capture_window. Inputs change 1 time unit after
// each rising edge and outputs are read at that same point, so every read
// reflects the edge just taken. The ADC data is a running counter, so the
// expected payload of any beat is known from the cycle it was driven in.
// A negedge monitor tallies accepted beats, tlast beats and done pulses.
// ---------------------------------------------------------------------------
module tb_adc_capture_window;

  localparam int DW = 128;
  localparam int CW = 16;

  logic          pl_clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          abort;
  logic          trigger;
  logic [CW-1:0] delay_cycles;
  logic [CW-1:0] capture_len;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;
  logic          overflow;

  int            checks = 0;
  int            errors = 0;
  int            seq    = 4096;
  logic [DW-1:0] drv_val;

  int            n_got  = 0;
  int            n_last = 0;
  int            n_done = 0;
  logic [DW-1:0] got [0:63];

  adc_capture_window #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .pl_clk        (pl_clk),
    .rst           (rst),
    .arm           (arm),
    .abort         (abort),
    .trigger       (trigger),
    .delay_cycles  (delay_cycles),
    .capture_len   (capture_len),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow)
  );

  always #5 pl_clk = ~pl_clk;

  // Accepted beats are counted where the handshake is stable mid-cycle.
  always @(negedge pl_clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (n_got < 64) got[n_got] <= m_axis_tdata;
        n_got <= n_got + 1;
        if (m_axis_tlast) n_last <= n_last + 1;
      end
      if (done) n_done <= n_done + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock, then present the next ADC sample.
  task automatic step_cycle();
    @(posedge pl_clk);
    #1;
    drv_val      = DW'(seq);
    s_axis_tdata = drv_val;
    seq++;
  endtask

  task automatic check_output(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int            g0, l0, d0;
    logic [DW-1:0] first, b2;

    rst           = 1'b1;
    arm           = 1'b0;
    abort         = 1'b0;
    trigger       = 1'b0;
    delay_cycles  = '0;
    capture_len   = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    drv_val       = '0;

    // Reset state
    repeat (3) step_cycle();
    check_bit("rst_tvalid", m_axis_tvalid, 1'b0);
    check_bit("rst_tlast", m_axis_tlast, 1'b0);
    check_output("rst_tdata", m_axis_tdata, '0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_overflow", overflow, 1'b0);
    check_bit("s_tready_tied", s_axis_tready, 1'b1);
    rst = 1'b0;
    step_cycle();

    // Test 1: delay 0, length 4, continuous stream
    g0 = n_got; l0 = n_last; d0 = n_done;
    delay_cycles = 16'd0; capture_len = 16'd4; arm = 1'b1;
    step_cycle();
    arm = 1'b0;
    check_bit("t1_busy_armed", busy, 1'b1);
    trigger = 1'b1;
    step_cycle();
    first = drv_val;
    check_bit("t1_no_beat_at_edge", m_axis_tvalid, 1'b0);
    step_cycle();
    check_bit("t1_first_valid", m_axis_tvalid, 1'b1);
    check_output("t1_first_data", m_axis_tdata, first);
    check_bit("t1_first_not_last", m_axis_tlast, 1'b0);
    repeat (3) step_cycle();
    check_bit("t1_done", done, 1'b1);
    check_bit("t1_last", m_axis_tlast, 1'b1);
    check_output("t1_last_data", m_axis_tdata, first + DW'(3));
    check_bit("t1_busy_idle", busy, 1'b0);
    step_cycle();
    check_bit("t1_done_one_cycle", done, 1'b0);
    check_bit("t1_drained", m_axis_tvalid, 1'b0);
    check_int("t1_beats", n_got - g0, 4);
    check_int("t1_tlast_count", n_last - l0, 1);
    check_int("t1_done_count", n_done - d0, 1);
    check_bit("t1_overflow", overflow, 1'b0);
    check_output("t1_got3", got[g0 + 3], first + DW'(3));

    // Test 2: delay 10, length 2 -- first beat is the one sampled at T+11
    g0 = n_got; l0 = n_last; d0 = n_done;
    trigger = 1'b0; delay_cycles = 16'd10; capture_len = 16'd2; arm = 1'b1;
    step_cycle();
    arm = 1'b0; trigger = 1'b1;
    step_cycle();
    repeat (10) step_cycle();
    check_bit("t2_busy_delay", busy, 1'b1);
    check_bit("t2_no_early_beat", m_axis_tvalid, 1'b0);
    first = drv_val;
    step_cycle();
    check_bit("t2_first_valid", m_axis_tvalid, 1'b1);
    check_output("t2_first_data", m_axis_tdata, first);
    step_cycle();
    check_output("t2_second_data", m_axis_tdata, first + DW'(1));
    check_bit("t2_last", m_axis_tlast, 1'b1);
    check_bit("t2_done", done, 1'b1);
    step_cycle();
    check_int("t2_beats", n_got - g0, 2);
    check_int("t2_done_count", n_done - d0, 1);

    // Test 3: length 8 with a 3-cycle stall starting on an empty register
    g0 = n_got; l0 = n_last; d0 = n_done;
    trigger = 1'b0; delay_cycles = 16'd0; capture_len = 16'd8; arm = 1'b1;
    step_cycle();
    arm = 1'b0; trigger = 1'b1;
    step_cycle();
    repeat (2) step_cycle();
    s_axis_tvalid = 1'b0;
    step_cycle();
    check_bit("t3_emptied", m_axis_tvalid, 1'b0);
    s_axis_tvalid = 1'b1; m_axis_tready = 1'b0;
    b2 = drv_val;
    step_cycle();
    check_bit("t3_stall0_valid", m_axis_tvalid, 1'b1);
    check_output("t3_stall0_data", m_axis_tdata, b2);
    check_bit("t3_no_overflow_yet", overflow, 1'b0);
    step_cycle();
    check_bit("t3_stall1_valid", m_axis_tvalid, 1'b1);
    check_output("t3_stall1_data", m_axis_tdata, b2);
    check_bit("t3_overflow_set", overflow, 1'b1);
    step_cycle();
    check_bit("t3_stall2_valid", m_axis_tvalid, 1'b1);
    check_output("t3_stall2_data", m_axis_tdata, b2);
    m_axis_tready = 1'b1;
    repeat (3) step_cycle();
    check_bit("t3_done", done, 1'b1);
    check_bit("t3_last", m_axis_tlast, 1'b1);
    step_cycle();
    check_int("t3_delivered", n_got - g0, 6);
    check_int("t3_tlast_count", n_last - l0, 1);
    check_int("t3_done_count", n_done - d0, 1);
    check_bit("t3_overflow_sticky", overflow, 1'b1);
    check_output("t3_got2", got[g0 + 2], b2);
    check_output("t3_got3", got[g0 + 3], b2 + DW'(3));
    check_output("t3_got5", got[g0 + 5], b2 + DW'(5));

    // Test 4: trigger already high at arm; then arm with length 0
    trigger = 1'b1;
    repeat (2) step_cycle();
    g0 = n_got; d0 = n_done;
    capture_len = 16'd3; arm = 1'b1;
    step_cycle();
    arm = 1'b0;
    check_bit("t4_overflow_cleared", overflow, 1'b0);
    check_bit("t4_busy", busy, 1'b1);
    repeat (3) step_cycle();
    check_bit("t4_still_armed", busy, 1'b1);
    check_bit("t4_no_capture", m_axis_tvalid, 1'b0);
    trigger = 1'b0;
    step_cycle();
    trigger = 1'b1;
    step_cycle();
    repeat (3) step_cycle();
    check_bit("t4_done", done, 1'b1);
    step_cycle();
    check_int("t4_beats", n_got - g0, 3);
    check_int("t4_done_count", n_done - d0, 1);
    capture_len = 16'd0; arm = 1'b1; trigger = 1'b0;
    step_cycle();
    arm = 1'b0;
    check_bit("t4_len0_idle", busy, 1'b0);
    trigger = 1'b1;
    repeat (2) step_cycle();
    check_bit("t4_len0_no_trig", busy, 1'b0);
    check_bit("t4_len0_no_beat", m_axis_tvalid, 1'b0);

    // Test 5: abort two beats into a length-16 window
    g0 = n_got; l0 = n_last; d0 = n_done;
    trigger = 1'b0; capture_len = 16'd16; arm = 1'b1;
    step_cycle();
    arm = 1'b0; trigger = 1'b1;
    step_cycle();
    repeat (2) step_cycle();
    first = drv_val;
    abort = 1'b1; m_axis_tready = 1'b0;
    step_cycle();
    abort = 1'b0;
    check_bit("t5_busy", busy, 1'b0);
    check_bit("t5_no_done", done, 1'b0);
    check_bit("t5_pending_kept", m_axis_tvalid, 1'b1);
    check_bit("t5_no_tlast", m_axis_tlast, 1'b0);
    check_output("t5_pending_data", m_axis_tdata, first - DW'(1));
    m_axis_tready = 1'b1;
    step_cycle();
    check_bit("t5_drained", m_axis_tvalid, 1'b0);
    step_cycle();
    check_int("t5_beats", n_got - g0, 2);
    check_int("t5_tlast_count", n_last - l0, 0);
    check_int("t5_done_count", n_done - d0, 0);
    g0 = n_got;
    trigger = 1'b0; capture_len = 16'd2; arm = 1'b1;
    step_cycle();
    arm = 1'b0; trigger = 1'b1;
    step_cycle();
    repeat (2) step_cycle();
    check_bit("t5_rearm_done", done, 1'b1);
    check_bit("t5_rearm_last", m_axis_tlast, 1'b1);
    step_cycle();
    check_int("t5_rearm_beats", n_got - g0, 2);

    // Test 6: reset mid-capture with a pending beat, then arm+edge together
    trigger = 1'b0; capture_len = 16'd8; arm = 1'b1;
    step_cycle();
    arm = 1'b0; trigger = 1'b1;
    step_cycle();
    step_cycle();
    m_axis_tready = 1'b0;
    step_cycle();
    check_bit("t6_overflow_before_rst", overflow, 1'b1);
    check_bit("t6_pending_before_rst", m_axis_tvalid, 1'b1);
    rst = 1'b1;
    step_cycle();
    check_bit("t6_rst_tvalid", m_axis_tvalid, 1'b0);
    check_bit("t6_rst_tlast", m_axis_tlast, 1'b0);
    check_output("t6_rst_tdata", m_axis_tdata, '0);
    check_bit("t6_rst_busy", busy, 1'b0);
    check_bit("t6_rst_done", done, 1'b0);
    check_bit("t6_rst_overflow", overflow, 1'b0);
    rst = 1'b0; m_axis_tready = 1'b1; trigger = 1'b0;
    step_cycle();
    check_bit("t6_idle_after_rst", busy, 1'b0);
    capture_len = 16'd4; arm = 1'b1; trigger = 1'b1;
    step_cycle();
    arm = 1'b0;
    repeat (3) step_cycle();
    check_bit("t6_same_cycle_armed", busy, 1'b1);
    check_bit("t6_same_cycle_no_beat", m_axis_tvalid, 1'b0);
    abort = 1'b1;
    step_cycle();
    abort = 1'b0;
    check_bit("t6_abort_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
